// File: rtl/majority_voter.sv
// Registered N-way bitwise majority voter for redundant datapaths. Channels that
// disagree with the vote for FAULT_THRESH consecutive samples are flagged and masked.
module majority_voter #(
   parameter int NUM_IN       = 3,
   parameter int WIDTH        = 8,
   parameter int FAULT_THRESH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic                    clear_fault,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [NUM_IN-1:0]       mismatch,
   output logic [NUM_IN-1:0]       fault,
   output logic                    all_fault
);

   localparam int CNT_W = $clog2(FAULT_THRESH + 1);
   localparam int VW    = $clog2(NUM_IN + 1) + 1;
   localparam logic [CNT_W-1:0] THRESH    = CNT_W'(FAULT_THRESH);
   localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(FAULT_THRESH - 1);

   // Strict majority of the active channels per bit; an even split resolves to 0.
   function automatic logic [WIDTH-1:0] vote_f(input logic [NUM_IN*WIDTH-1:0] d,
                                              input logic [NUM_IN-1:0]       act);
      logic [VW-1:0]    n_act;
      logic [VW-1:0]    ones;
      logic [WIDTH-1:0] v;
      n_act = '0;
      v     = '0;
      for (int i = 0; i < NUM_IN; i++) n_act = n_act + VW'(act[i]);
      for (int b = 0; b < WIDTH; b++) begin
         ones = '0;
         for (int i = 0; i < NUM_IN; i++) ones = ones + VW'(act[i] & d[i*WIDTH+b]);
         v[b] = (ones << 1) > n_act;
      end
      return v;
   endfunction

   function automatic logic [NUM_IN-1:0] diff_f(input logic [NUM_IN*WIDTH-1:0] d,
                                               input logic [NUM_IN-1:0]       act,
                                               input logic [WIDTH-1:0]        v);
      logic [NUM_IN-1:0] m;
      for (int i = 0; i < NUM_IN; i++) m[i] = act[i] && (d[i*WIDTH +: WIDTH] != v);
      return m;
   endfunction

   logic                    vld_p1;
   logic [WIDTH-1:0]        data_p1;
   logic [NUM_IN-1:0]       mm_p1;
   logic [NUM_IN-1:0]       fault_r;
   logic [CNT_W-1:0]        cnt_r   [NUM_IN];

   logic [NUM_IN-1:0]       active_p0;
   logic [WIDTH-1:0]        vote_p0;
   logic [NUM_IN-1:0]       mm_p0;
   logic                    all_fault_p0;
   logic [NUM_IN-1:0]       fault_nxt;
   logic [CNT_W-1:0]        cnt_nxt [NUM_IN];

   // Stage p0: vote with the mask registered at the start of the cycle
   assign active_p0    = ~fault_r;
   assign all_fault_p0 = &fault_r;
   assign vote_p0      = vote_f(in_data, active_p0);
   assign mm_p0        = diff_f(in_data, active_p0, vote_p0);

   // A clear discards this sample's health update even though the sample is voted.
   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         cnt_nxt[i]   = cnt_r[i];
         fault_nxt[i] = fault_r[i];
      end
      if (clear_fault) begin
         for (int i = 0; i < NUM_IN; i++) begin
            cnt_nxt[i]   = '0;
            fault_nxt[i] = 1'b0;
         end
      end else if (in_valid) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (active_p0[i]) begin
               if (mm_p0[i]) begin
                  if (cnt_r[i] != THRESH) cnt_nxt[i] = cnt_r[i] + CNT_W'(1);
                  if (cnt_r[i] == THRESH_M1) fault_nxt[i] = 1'b1;
               end else begin
                  cnt_nxt[i] = '0;
               end
            end
         end
      end
   end

   // Stage p1: registered outputs and channel health state
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         mm_p1   <= '0;
         fault_r <= '0;
         for (int i = 0; i < NUM_IN; i++) cnt_r[i] <= '0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            mm_p1 <= mm_p0;
            if (!all_fault_p0) data_p1 <= vote_p0;
         end
         fault_r <= fault_nxt;
         for (int i = 0; i < NUM_IN; i++) cnt_r[i] <= cnt_nxt[i];
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign mismatch  = mm_p1;
   assign fault     = fault_r;
   assign all_fault = &fault_r;

endmodule

// File: tb/tb_majority_voter.sv
// Scoreboard bench for majority_voter (3 channels x 8 bits, threshold 3):
// stimulus pushes hand-computed expectations, a negedge monitor pops on out_valid.
module tb_majority_voter;
   localparam int NUM_IN       = 3;
   localparam int WIDTH        = 8;
   localparam int FAULT_THRESH = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [23:0] in_data;
   logic        clear_fault;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  mismatch;
   logic [2:0]  fault;
   logic        all_fault;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] mm;
      logic [2:0] f;
      logic       af;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   logic [7:0] sw_d [8] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
   logic [2:0] sw_m [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000};

   always #5 clk = ~clk;

   majority_voter #(
      .NUM_IN(NUM_IN),
      .WIDTH(WIDTH),
      .FAULT_THRESH(FAULT_THRESH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .clear_fault(clear_fault),
      .out_valid(out_valid),
      .out_data(out_data),
      .mismatch(mismatch),
      .fault(fault),
      .all_fault(all_fault)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                       input logic clr, input logic [7:0] ed, input logic [2:0] emm,
                       input logic [2:0] ef, input logic eaf);
      exp_t x;
      @(posedge clk);
      #1;
      in_valid    = 1'b1;
      clear_fault = clr;
      in_data     = {c2, c1, c0};
      x.d = ed; x.mm = emm; x.f = ef; x.af = eaf;
      sb.push_back(x);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      clear_fault = 1'b0;
   endtask

   // Monitor: one expectation per presented output
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: out_valid=1 with data 0x%0h, expected no output", out_data);
         end else begin
            e = sb.pop_front();
            chk($sformatf("out%0d.data", n_out), 32'(out_data), 32'(e.d));
            chk($sformatf("out%0d.mismatch", n_out), 32'(mismatch), 32'(e.mm));
            chk($sformatf("out%0d.fault", n_out), 32'(fault), 32'(e.f));
            chk($sformatf("out%0d.all_fault", n_out), 32'(all_fault), 32'(e.af));
         end
         n_out++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d outputs seen", n_out);
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] pv;
      rst         = 1'b1;
      in_valid    = 1'($urandom);
      in_data     = 24'($urandom);
      clear_fault = 1'($urandom);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("rst%0d.out_valid", k), 32'(out_valid), 0);
         chk($sformatf("rst%0d.out_data", k), 32'(out_data), 0);
         chk($sformatf("rst%0d.mismatch", k), 32'(mismatch), 0);
         chk($sformatf("rst%0d.fault", k), 32'(fault), 0);
         chk($sformatf("rst%0d.all_fault", k), 32'(all_fault), 0);
         @(posedge clk);
         #1;
         in_valid    = 1'($urandom);
         in_data     = 24'($urandom);
         clear_fault = 1'($urandom);
      end
      rst = 1'b0; in_valid = 1'b0; clear_fault = 1'b0;

      // two ch2 mismatches, then reset with a sample in flight
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b1; in_data = {8'h00, 8'h5A, 8'h5A};
      @(negedge clk);
      @(negedge clk);
      chk("midrst.out_valid", 32'(out_valid), 0);
      chk("midrst.out_data", 32'(out_data), 0);
      chk("midrst.fault", 32'(fault), 0);
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      // counters must have restarted: two more mismatches do not fault ch2
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      send(8'h33, 8'h33, 8'h33, 1'b0, 8'h33, 3'b000, 3'b000, 1'b0);

      // basic vote and 3-input truth table
      send(8'hF0, 8'hCC, 8'hAA, 1'b0, 8'hE8, 3'b111, 3'b000, 1'b0);
      for (int p = 0; p < 8; p++) begin
         pv = 3'(p);
         send({8{pv[0]}}, {8{pv[1]}}, {8{pv[2]}}, 1'b0, sw_d[p], sw_m[p], 3'b000, 1'b0);
      end

      // agreement between mismatches resets the counter
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      send(8'h5A, 8'h5A, 8'h5A, 1'b0, 8'h5A, 3'b000, 3'b000, 1'b0);
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      send(8'h5A, 8'h5A, 8'h5A, 1'b0, 8'h5A, 3'b000, 3'b000, 1'b0);

      // three mismatches with an idle gap fault ch2 on the third
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      idle();
      @(negedge clk);
      @(negedge clk);
      chk("gap.out_valid", 32'(out_valid), 0);
      chk("gap.out_data", 32'(out_data), 32'h5A);
      chk("gap.mismatch", 32'(mismatch), 32'b100);
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b000, 1'b0);
      send(8'h5A, 8'h5A, 8'h00, 1'b0, 8'h5A, 3'b100, 3'b100, 1'b0);

      // ch2 masked: tie bits resolve to 0
      send(8'hFF, 8'h0F, 8'hFF, 1'b0, 8'h0F, 3'b001, 3'b100, 1'b0);

      // clear with a sample: voted with old mask, health reset
      send(8'hFF, 8'h00, 8'hFF, 1'b1, 8'h00, 3'b001, 3'b000, 1'b0);
      send(8'h00, 8'hFF, 8'hFF, 1'b0, 8'hFF, 3'b001, 3'b000, 1'b0);
      send(8'h00, 8'hFF, 8'hFF, 1'b0, 8'hFF, 3'b001, 3'b000, 1'b0);
      send(8'hFF, 8'h00, 8'hFF, 1'b0, 8'hFF, 3'b010, 3'b000, 1'b0);
      send(8'h33, 8'h33, 8'h33, 1'b0, 8'h33, 3'b000, 3'b000, 1'b0);

      // fault every channel, then vote with none active
      send(8'hF0, 8'hCC, 8'hAA, 1'b0, 8'hE8, 3'b111, 3'b000, 1'b0);
      send(8'hF0, 8'hCC, 8'hAA, 1'b0, 8'hE8, 3'b111, 3'b000, 1'b0);
      send(8'hF0, 8'hCC, 8'hAA, 1'b0, 8'hE8, 3'b111, 3'b111, 1'b1);
      send(8'h12, 8'h34, 8'h56, 1'b0, 8'hE8, 3'b000, 3'b111, 1'b1);

      // standalone clear pulse
      @(posedge clk);
      #1;
      in_valid = 1'b0; clear_fault = 1'b1;
      @(posedge clk);
      #1;
      clear_fault = 1'b0;
      @(negedge clk);
      chk("clear.fault", 32'(fault), 0);
      chk("clear.all_fault", 32'(all_fault), 0);
      send(8'h0F, 8'h0F, 8'hF0, 1'b0, 8'h0F, 3'b100, 3'b000, 1'b0);

      idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/majority_voter.md
Name: majority_voter

Overview:
Parametrised, registered N-way bitwise majority voter with per-channel fault tracking. It is the successor to the single-bit 3-input majority gate, generalised to NUM_IN channels of WIDTH bits. It adds a valid handshake, consecutive-disagreement counters and sticky fault flags. A faulted channel is masked out of later votes, so the block sits in front of redundant (TMR/NMR) datapaths and feeds the downstream consumer a single voted word plus health status.

Parameters:
NUM_IN, 3, number of voted channels; odd, >= 3.
WIDTH, 8, bits per channel.
FAULT_THRESH, 3, consecutive mismatching valid samples that mark a channel faulted; >= 1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data carries a sample this cycle.
in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
clear_fault  input  1  one-cycle pulse; clears all fault flags and counters.
out_valid  output  1  out_data/mismatch valid; in_valid delayed 1 cycle.
out_data  output  WIDTH  voted word.
mismatch  output  NUM_IN  per-channel: active channel differed from the vote.
fault  output  NUM_IN  sticky per-channel fault flags.
all_fault  output  1  every channel faulted; no vote possible.

Behaviour:
- Reset (rst=1 at edge) sets all outputs and all internal counters to 0. rst overrides every other input, including mid-stream: the in-flight sample is dropped and out_valid=0 the next cycle.
- Active mask = ~fault as registered at the start of the cycle.
- Vote, per bit b: out bit = 1 iff the count of active channels with bit b = 1 is strictly greater than (active channel count)/2. Ties are therefore possible only with an even active count, and resolve to 0.
- Latency: exactly 1 cycle. On the edge where in_valid=1: out_data <= vote, mismatch[i] <= active[i] && (ch_i != vote), and out_valid <= 1.
- If in_valid=0: out_valid <= 0, while out_data and mismatch hold their values.
- All channels faulted: out_data holds its previous value, mismatch <= 0, out_valid still follows in_valid, and all_fault=1 (combinational from fault).
- Counters: each channel has a saturating counter of width clog2(FAULT_THRESH+1). On each in_valid sample for an active channel:
  - mismatch increments the counter;
  - a match clears it to 0.
  - Cycles with in_valid=0 leave counters unchanged.
- Fault set: on the same edge at which a counter reaches FAULT_THRESH, fault[i] <= 1. It is therefore visible together with that sample's out_valid. The channel is excluded from the vote starting with the next sample.
- Faulted channels: the counter is frozen and mismatch[i] reports 0.
- clear_fault=1: at the edge, fault <= 0 and all counters <= 0. If in_valid is also 1, that sample is still voted with the pre-clear mask and outputs update normally, but its counter/fault updates are discarded (clear wins).
- No backpressure: the block accepts a sample every cycle.

Test Plan:
1. rst=1 for 2 cycles with random inputs -> out_valid, out_data, mismatch, fault, all_fault all 0. Assert rst mid-stream -> next-cycle out_valid=0 and counters cleared.
2. NUM_IN=3, WIDTH=8, FAULT_THRESH=3. ch0=0xF0, ch1=0xCC, ch2=0xAA, in_valid=1 -> next cycle out_valid=1, out_data=0xE8, mismatch=3'b111, fault=0. Also sweep single-bit patterns 0..7 across the channels and compare against the 3-input majority truth table.
3. ch0=ch1=0x5A, ch2=0x00 for 3 consecutive valid samples -> out_data=0x5A each time, mismatch=3'b100. fault[2]=1 is visible with the 3rd sample's output. Inserting an in_valid=0 gap between samples does not change the result.
4. Two mismatching samples on ch2, then an agreeing sample, then two more mismatching samples -> fault[2] stays 0 (counter reset on agreement).
5. With fault=3'b100: ch0=0xFF, ch1=0x0F, ch2=0xFF -> out_data=0x0F (tie bits resolve to 0), mismatch=3'b001, all_fault=0. Then force ch0 and ch1 faulted as well -> all_fault=1 and out_data holds its last value.
6. clear_fault=1 together with a mismatching sample while fault=3'b100 -> that sample's output uses the mask 3'b011; afterwards fault=0 and all counters=0, and the next sample votes all 3 channels.
